// File: rtl/vec_regfile.sv
// Vector register file: DEPTH x WIDTH registers, two combinational read ports and a
// command port (LOADS/OUTR/CLR/LOADD). Define REGFILE_BYPASS_EN for write-to-read bypass.
module vec_regfile #(
  parameter int WIDTH = 512,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [AW-1:0]    cmd_addr,
  input  logic [WIDTH-1:0] wdata1,
  input  logic [WIDTH-1:0] wdata2,
  input  logic [AW-1:0]    rd_addr_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  typedef enum logic [1:0] {
    OP_LOADS = 2'b00,
    OP_OUTR  = 2'b01,
    OP_CLR   = 2'b10,
    OP_LOADD = 2'b11
  } op_e;

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             accept;
  logic [AW-1:0]    addr_nxt;
  op_e              op;

  assign op        = op_e'(cmd_op);
  assign cmd_ready = !out_valid_q || out_ready;
  assign accept    = cmd_valid && cmd_ready;
  // DEPTH is a power of two, so AW-bit addition wraps DEPTH-1 back to 0.
  assign addr_nxt  = cmd_addr + AW'(1);

  always_comb begin
    regs_d      = regs_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (accept) begin
      case (op)
        OP_LOADS: regs_d[cmd_addr] = wdata1;
        OP_CLR:   regs_d[cmd_addr] = '0;
        OP_LOADD: begin
          regs_d[cmd_addr] = wdata1;
          regs_d[addr_nxt] = wdata2;
        end
        OP_OUTR: begin
          out_data_d  = regs_q[cmd_addr];
          out_valid_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q      <= '{default: '0};
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      regs_q      <= regs_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef REGFILE_BYPASS_EN
  // regs_d already carries this cycle's accepted write, so reading it is the bypass.
  assign rd_data_a = regs_d[rd_addr_a];
  assign rd_data_b = regs_d[rd_addr_b];
`else
  assign rd_data_a = regs_q[rd_addr_a];
  assign rd_data_b = regs_q[rd_addr_b];
`endif

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule
